// File: rtl/gray_stream_monitor_pkg.sv
// Shared types and constants for the Gray-stream monitor: FSM encoding,
// error-counter ceiling and the seven-segment glyph table.
package gray_stream_monitor_pkg;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_TRACK = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  localparam logic [7:0] ERR_CNT_MAX = 8'd255;

  // Active-high glyphs, bit order {g,f,e,d,c,b,a}, digits 0..F.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] seg_pattern(input logic [3:0] digit,
                                             input logic       active_low);
    seg_pattern = active_low ? ~SEG_TABLE[digit] : SEG_TABLE[digit];
  endfunction

endpackage

// File: rtl/gray_stream_monitor_if.sv
// Bundle between the Gray counter side (master) and the monitor (slave).
interface gray_stream_monitor_if #(
  parameter int W = 3
);
  logic [W-1:0] gray_in;
  logic         ack_err;
  logic [W-1:0] bin_out;
  logic [6:0]   seg;
  logic         step;
  logic         dir_up;
  logic         step_err;
  logic         err_sticky;
  logic [7:0]   err_count;
  logic         valid;

  modport master (
    output gray_in, ack_err,
    input  bin_out, seg, step, dir_up, step_err, err_sticky, err_count, valid
  );

  modport slave (
    input  gray_in, ack_err,
    output bin_out, seg, step, dir_up, step_err, err_sticky, err_count, valid
  );
endinterface

// File: rtl/gray_stream_monitor_gray_sync.sv
// Plain multi-flop synchroniser for a Gray word arriving from another clock
// domain; Gray coding guarantees at most one bit is in flight per change.
module gray_sync #(
  parameter int W           = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_sync [SYNC_STAGES];

  // NOTE: every stage is reset, so the first post-reset sample can never be stale pre-reset data.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/gray_stream_monitor.sv
// Gray-stream monitor: synchronises a slow Gray word, converts it to binary,
// drives a seven-segment digit and flags illegal multi-bit transitions.
module gray_stream_monitor
  import gray_stream_monitor_pkg::*;
#(
  parameter int W              = 3,
  parameter int SYNC_STAGES    = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                 clk,
  input  logic                 clr,
  gray_stream_monitor_if.slave bus
);

  localparam int WAIT_W = $clog2(SYNC_STAGES + 1);

  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  state_t            r_state;
  logic [WAIT_W-1:0] r_wait;
  logic [W-1:0]      r_g_prev;
  logic [W-1:0]      r_bin_out;
  logic [6:0]        r_seg;
  logic              r_step;
  logic              r_dir_up;
  logic              r_step_err;
  logic              r_err_sticky;
  logic [7:0]        r_err_count;
  logic              r_valid;

  logic [W-1:0]      w_g_s;
  logic [W-1:0]      w_diff;
  logic [W-1:0]      w_bin_s;
  logic              w_change;
  logic              w_illegal;
  logic              w_dir_up;

  gray_sync #(
    .W           (W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .clr (clr),
    .i_d (bus.gray_in),
    .o_q (w_g_s)
  );

  // NOTE: every w_ signal is assigned on every pass, so no latch can be inferred.
  always_comb begin
    w_diff    = w_g_s ^ r_g_prev;
    w_change  = |w_diff;
    // More than one bit set <=> clearing the lowest set bit leaves something.
    w_illegal = |(w_diff & (w_diff - 1'b1));
    w_bin_s   = gray2bin(w_g_s);
    w_dir_up  = (w_bin_s == r_bin_out + 1'b1);
  end

  // NOTE: non-blocking assignments only, so every branch reads pre-edge state.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state      <= S_INIT;
      r_wait       <= '0;
      r_g_prev     <= '0;
      r_bin_out    <= '0;
      r_seg        <= seg_pattern(4'd0, SEG_ACTIVE_LOW);
      r_step       <= 1'b0;
      r_dir_up     <= 1'b0;
      r_step_err   <= 1'b0;
      r_err_sticky <= 1'b0;
      r_err_count  <= '0;
      r_valid      <= 1'b0;
    end else begin
      r_step     <= 1'b0;
      r_step_err <= 1'b0;
      case (r_state)
        S_INIT: begin
          // Let the synchroniser flush before trusting g_s as a baseline.
          if (r_wait == WAIT_W'(SYNC_STAGES)) begin
            r_g_prev  <= w_g_s;
            r_bin_out <= w_bin_s;
            r_seg     <= seg_pattern(4'(w_bin_s), SEG_ACTIVE_LOW);
            r_valid   <= 1'b1;
            r_state   <= S_TRACK;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        S_TRACK, S_FAULT: begin
          if (w_change) begin
            r_g_prev  <= w_g_s;
            r_bin_out <= w_bin_s;
            r_seg     <= seg_pattern(4'(w_bin_s), SEG_ACTIVE_LOW);
            if (w_illegal) begin
              r_step_err   <= 1'b1;
              r_err_sticky <= 1'b1;
              r_state      <= S_FAULT;
              if (r_err_count != ERR_CNT_MAX) r_err_count <= r_err_count + 1'b1;
            end else begin
              r_step   <= 1'b1;
              r_dir_up <= w_dir_up;
            end
          end
          // A fresh error in the same cycle outranks the acknowledge.
          if (r_state == S_FAULT && bus.ack_err && !(w_change && w_illegal)) begin
            r_err_sticky <= 1'b0;
            r_state      <= S_TRACK;
          end
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

  assign bus.bin_out    = r_bin_out;
  assign bus.seg        = r_seg;
  assign bus.step       = r_step;
  assign bus.dir_up     = r_dir_up;
  assign bus.step_err   = r_step_err;
  assign bus.err_sticky = r_err_sticky;
  assign bus.err_count  = r_err_count;
  assign bus.valid      = r_valid;

endmodule

// File: tb/tb_gray_stream_monitor.sv
// Directed bench for gray_stream_monitor: a reference model pushes expected
// step/error results to a queue, popped when the DUT emits its pulse.
module tb_gray_stream_monitor;

  localparam int SYNC_STAGES = 2;
  localparam int LAT         = SYNC_STAGES + 1;

  typedef struct packed {
    logic [2:0] bin;
    logic       step;
    logic       dir;
    logic       err;
    logic       sticky;
    logic [7:0] cnt;
    logic [6:0] seg;
  } exp_t;

  logic clk;
  logic clr;

  gray_stream_monitor_if #(.W(3)) bus ();

  gray_stream_monitor #(
    .W              (3),
    .SYNC_STAGES    (SYNC_STAGES),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Active-low glyphs {g,f,e,d,c,b,a} for digits 0..7.
  logic [6:0] seg_low [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};

  exp_t exp_q [$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_steps = 0;

  logic [2:0] m_gprev;
  logic [2:0] m_bin;
  logic       m_dir;
  logic       m_sticky;
  logic [7:0] m_cnt;
  logic       m_fault;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] tb_g2b(input logic [2:0] g);
    return g ^ (g >> 1) ^ (g >> 2);
  endfunction

  task automatic model_reset();
    m_gprev  = 3'b000;
    m_bin    = 3'd0;
    m_dir    = 1'b0;
    m_sticky = 1'b0;
    m_cnt    = 8'd0;
    m_fault  = 1'b0;
  endtask

  // Counts negedges after reset release until valid rises; gray_in must be stable.
  task automatic wait_valid(input string tag, input logic [2:0] g_held);
    int  lat;
    bit  pulse;
    lat   = 0;
    pulse = 0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(negedge clk);
      if (bus.step || bus.step_err) pulse = 1;
      if (bus.valid) lat = k;
    end
    check({tag, " valid latency"}, lat, LAT);
    check({tag, " no pulse in init"}, pulse, 0);
    check({tag, " bin"}, bus.bin_out, tb_g2b(g_held));
    check({tag, " seg"}, bus.seg, seg_low[tb_g2b(g_held)]);
  endtask

  // Drives one Gray change; ack_at_update raises ack_err for the edge that sees it.
  task automatic step_gray(input logic [2:0] g, input logic ack_at_update, input string tag);
    exp_t       e;
    logic [2:0] d;
    int         lat;
    d     = g ^ m_gprev;
    e.bin = tb_g2b(g);
    if ((d & (d - 3'd1)) == 3'd0) begin
      e.step = 1'b1;
      e.err  = 1'b0;
      m_dir  = (e.bin == 3'(m_bin + 3'd1));
      if (m_fault && ack_at_update) begin
        m_sticky = 1'b0;
        m_fault  = 1'b0;
      end
    end else begin
      e.step   = 1'b0;
      e.err    = 1'b1;
      m_sticky = 1'b1;
      m_fault  = 1'b1;
      if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
    end
    m_gprev  = g;
    m_bin    = e.bin;
    e.dir    = m_dir;
    e.sticky = m_sticky;
    e.cnt    = m_cnt;
    e.seg    = seg_low[e.bin];
    exp_q.push_back(e);

    bus.gray_in = g;
    lat = 0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      if (k == LAT) bus.ack_err = ack_at_update;
      @(negedge clk);
      bus.ack_err = 1'b0;
      if (bus.step || bus.step_err) lat = k;
    end
    check({tag, " latency"}, lat, LAT);
    if (exp_q.size() != 0) e = exp_q.pop_front();
    if (lat != 0) begin
      if (bus.step) n_steps++;
      check({tag, " step"}, bus.step, e.step);
      check({tag, " step_err"}, bus.step_err, e.err);
      check({tag, " dir_up"}, bus.dir_up, e.dir);
      check({tag, " bin_out"}, bus.bin_out, e.bin);
      check({tag, " seg"}, bus.seg, e.seg);
      check({tag, " err_sticky"}, bus.err_sticky, e.sticky);
      check({tag, " err_count"}, bus.err_count, e.cnt);
      check({tag, " valid"}, bus.valid, 1);
      @(negedge clk);
      check({tag, " pulse width"}, {bus.step, bus.step_err}, 2'b00);
    end
  endtask

  task automatic ack_pulse(input string tag);
    bus.ack_err = 1'b1;
    @(negedge clk);
    bus.ack_err = 1'b0;
    if (m_fault) begin
      m_sticky = 1'b0;
      m_fault  = 1'b0;
    end
    check({tag, " err_sticky"}, bus.err_sticky, m_sticky);
    check({tag, " err_count"}, bus.err_count, m_cnt);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [2:0] up_seq [8] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};

  initial begin
    clr         = 1'b0;
    bus.gray_in = 3'b000;
    bus.ack_err = 1'b0;
    model_reset();

    // Reset state while clr is held low.
    @(negedge clk);
    check("rst valid", bus.valid, 0);
    check("rst bin_out", bus.bin_out, 0);
    check("rst seg", bus.seg, 7'h40);
    check("rst err_count", bus.err_count, 0);
    check("rst err_sticky", bus.err_sticky, 0);
    check("rst pulses", {bus.step, bus.step_err, bus.dir_up}, 3'b000);
    @(negedge clk);
    clr = 1'b1;
    wait_valid("init", 3'b000);

    // Full up sequence including the 7 -> 0 wrap.
    n_steps = 0;
    for (int i = 0; i < 8; i++) begin
      step_gray(up_seq[i], 1'b0, "up");
      idle(6);
    end
    check("up step count", n_steps, 8);
    check("up err_count", bus.err_count, 0);

    // Down steps, including 000 -> 100 wrap downward.
    step_gray(3'b100, 1'b0, "down wrap");
    step_gray(3'b000, 1'b0, "up wrap");
    step_gray(3'b001, 1'b0, "up1");
    step_gray(3'b011, 1'b0, "up2");
    step_gray(3'b001, 1'b0, "down");
    step_gray(3'b000, 1'b0, "down0");

    // Illegal jump, then acknowledge.
    step_gray(3'b011, 1'b0, "illegal1");
    idle(2);
    check("fault sticky held", bus.err_sticky, 1);
    ack_pulse("ack1");

    // Ack coinciding with illegal change, in TRACK and then in FAULT.
    step_gray(3'b100, 1'b1, "illegal2 ack");
    step_gray(3'b011, 1'b1, "illegal3 ack");
    // Legal step with ack while in FAULT clears the sticky flag.
    step_gray(3'b010, 1'b1, "legal ack");
    ack_pulse("ack in track");
    step_gray(3'b011, 1'b0, "back to 011");

    // Saturation of the error counter.
    for (int i = 0; i < 300; i++) step_gray((i % 2 == 0) ? 3'b000 : 3'b011, 1'b0, "sat");
    check("sat err_count", bus.err_count, 8'd255);
    check("sat err_sticky", bus.err_sticky, 1);

    // Mid-flight asynchronous reset.
    bus.gray_in = 3'b000;
    @(negedge clk);
    clr = 1'b0;
    #1;
    check("mid rst valid", bus.valid, 0);
    check("mid rst bin_out", bus.bin_out, 0);
    check("mid rst seg", bus.seg, 7'h40);
    check("mid rst err_count", bus.err_count, 0);
    check("mid rst err_sticky", bus.err_sticky, 0);
    check("mid rst pulses", {bus.step, bus.step_err, bus.dir_up}, 3'b000);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    wait_valid("reinit", 3'b000);
    step_gray(3'b001, 1'b0, "post rst up");

    check("queue drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_stream_monitor.md
Name: gray_stream_monitor

Overview:
Downstream consumer of the 3-bit Gray-code counter output. Synchronises the Gray word from the slow divided-clock domain into the system clock domain and converts it to binary. Drives a seven-segment digit and flags illegal multi-bit transitions (sticky error, saturating error count). It sits between the Gray counter top level and the board display pins.

Parameters:
W, 3, Gray/binary word width (2..4; seven-segment decode covers 0..F)
SYNC_STAGES, 2, synchroniser flop count on gray_in (>=2)
SEG_ACTIVE_LOW, 1, 1 = segment outputs inverted (common-anode board)

Ports:
clk  in  1  system clock
clr  in  1  reset, asynchronous, active-low
gray_in  in  W  Gray word from counter (asynchronous to clk)
ack_err  in  1  clears err_sticky (level, sampled on clk)
bin_out  out  W  registered binary equivalent of current Gray word
seg  out  7  segments {g,f,e,d,c,b,a} for bin_out
step  out  1  one-cycle pulse on each legal single-bit change
dir_up  out  1  direction of last legal step (1 = increment)
step_err  out  1  one-cycle pulse on an illegal change (Hamming distance >1)
err_sticky  out  1  held high from first error until acknowledged
err_count  out  8  illegal-change count, saturates at 255
valid  out  1  high once first sample captured after reset

Behaviour:
- Reset (clr=0, any time, asynchronous): sync chain, g_prev, bin_out, dir_up, step, step_err, err_sticky, err_count, valid all 0; seg shows digit 0 (respecting SEG_ACTIVE_LOW); FSM -> S_INIT. Operation restarts identically after mid-run reset.
- Synchroniser: SYNC_STAGES flops on gray_in; g_s = last stage. No logic between stages.
- Conversion: b[W-1]=g[W-1]; b[i]=b[i+1]^g[i] for i<W-1.
- FSM states:
  - S_INIT: wait counter runs SYNC_STAGES cycles, then g_prev<=g_s, bin_out<=bin(g_s), valid<=1, -> S_TRACK. No step/step_err in S_INIT.
  - S_TRACK: when g_s==g_prev, nothing. When g_s!=g_prev:
    - Hamming distance 1 -> step pulse. dir_up=1 if bin(g_s)==bin(g_prev)+1 mod 2^W, else 0.
    - Distance >1 -> step_err pulse, err_sticky<=1, err_count+1 (saturating), -> S_FAULT.
    - In both cases g_prev<=g_s, bin_out<=bin(g_s).
  - S_FAULT: identical change handling to S_TRACK; err_sticky held.
    - ack_err=1 with no illegal change that cycle -> err_sticky<=0, -> S_TRACK.
    - ack_err with simultaneous illegal change: error wins (stay S_FAULT, sticky 1, count increments).
    - ack_err in S_TRACK: no effect.
- Wrap-around: Gray 100->000 (bin 7->0) is a legal up step; 000->100 is a legal down step.
- Latency: gray_in change -> bin_out/step/step_err update = SYNC_STAGES+1 clk cycles. seg is registered from the same next-state value, so it updates in the same cycle as bin_out.
- All outputs registered; no combinational path from input to output.
- err_count at 255 stays 255; step_err still pulses.

Decomposition:
- Shared package: state encoding (S_INIT, S_TRACK, S_FAULT), ERR_CNT_MAX=255, and a 16-entry seven-segment pattern constant table (active-high; inversion applied per SEG_ACTIVE_LOW).
- One sub-module: gray_sync (parameterised W, SYNC_STAGES multi-flop synchroniser, async active-low clr).

Test Plan:
- Reset, then hold gray_in=000 -> valid=1 at cycle SYNC_STAGES+1; bin_out=0, seg=digit 0 (active-low 7'b1000000), no step pulses.
- Full up sequence 000,001,011,010,110,111,101,100,000 held 10 cycles each -> 8 step pulses, dir_up=1 each time, bin_out 1..7 then 0 (wrap counted as up), err_count=0.
- Down step 011->001 -> step=1, dir_up=0, bin_out 2->1.
- Illegal jump 000->011 -> step_err one cycle, err_sticky=1, err_count=1, bin_out=2, state S_FAULT. Then ack_err=1 -> err_sticky=0 next cycle.
- ack_err asserted in the same cycle as a second illegal change 011->100 -> err_sticky stays 1, err_count=2.
- 300 illegal jumps (alternate 000/011) -> err_count saturates at 255. Then assert clr mid-sequence -> all outputs 0 immediately, valid re-asserts SYNC_STAGES+1 cycles after release.
